// File: rtl/sequence_start_arbiter.sv
// Arbitrates four single-cycle start requests onto one sequencer, granting only
// on an alignment strobe and enforcing a post-sequence holdoff and busy timeout.
module sequence_start_arbiter #(
    parameter int BUSY_TIMEOUT  = 1000000,
    parameter int TIMEOUT_WIDTH = 21
) (
    input  logic        evgTxClk,
    input  logic        evgTxReset_n,
    input  logic [3:0]  req,
    input  logic [3:0]  enableMask,
    input  logic [15:0] holdoffTicks,
    input  logic        alignStrobe,
    input  logic        seqDone,
    input  logic        clearFlags,
    output logic        seqStart,
    output logic [1:0]  seqSelect,
    output logic        busy,
    output logic [3:0]  pending,
    output logic [3:0]  overrunFlags,
    output logic        timeoutFlag
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AWAIT_ALIGN,
        ST_START,
        ST_BUSY,
        ST_HOLDOFF
    } state_t;

    localparam logic [TIMEOUT_WIDTH-1:0] TIMER_LAST = TIMEOUT_WIDTH'(BUSY_TIMEOUT - 1);

    state_t                   state_q, state_d;
    logic [1:0]               sel_q, sel_d;
    logic                     start_q, start_d;
    logic                     busy_q, busy_d;
    logic [3:0]               pending_q, pending_d;
    logic [3:0]               overrun_q, overrun_d;
    logic                     timeout_q, timeout_d;
    logic [TIMEOUT_WIDTH-1:0] timer_q, timer_d;
    logic [15:0]              hold_q, hold_d;

    logic [3:0]               clr_vec;
    logic [3:0]               overrun_set;
    logic [1:0]               first_idx;
    logic                     timeout_set;

    // A request landing on its own START-cycle clear re-arms pending without an overrun.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_req
            assign clr_vec[gi]     = (state_q == ST_START) && (sel_q == 2'(gi));
            assign pending_d[gi]   = enableMask[gi] & ((pending_q[gi] & ~clr_vec[gi]) | req[gi]);
            assign overrun_set[gi] = req[gi] & enableMask[gi] & pending_q[gi] & ~clr_vec[gi];
            assign overrun_d[gi]   = overrun_set[gi] | (overrun_q[gi] & ~clearFlags);
        end
    endgenerate

    always_comb begin
        first_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (pending_q[i]) begin
                first_idx = 2'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        timer_d     = timer_q;
        hold_d      = hold_q;
        timeout_set = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|pending_q) begin
                    sel_d   = first_idx;
                    state_d = ST_AWAIT_ALIGN;
                end
            end
            ST_AWAIT_ALIGN: begin
                if (alignStrobe) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                timer_d = '0;
                state_d = ST_BUSY;
            end
            ST_BUSY: begin
                // A timeout is treated exactly like a completion, only flagged.
                if (seqDone || (timer_q == TIMER_LAST)) begin
                    timeout_set = ~seqDone;
                    timer_d     = '0;
                    hold_d      = holdoffTicks;
                    state_d     = (holdoffTicks == 16'd0) ? ST_IDLE : ST_HOLDOFF;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_HOLDOFF: begin
                if (hold_q == 16'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    hold_d = hold_q - 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        start_d   = (state_d == ST_START);
        busy_d    = (state_d != ST_IDLE);
        timeout_d = timeout_set | (timeout_q & ~clearFlags);
    end

    always_ff @(posedge evgTxClk or negedge evgTxReset_n) begin
        if (!evgTxReset_n) begin
            state_q   <= ST_IDLE;
            sel_q     <= 2'd0;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
            pending_q <= 4'd0;
            overrun_q <= 4'd0;
            timeout_q <= 1'b0;
            timer_q   <= '0;
            hold_q    <= 16'd0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            start_q   <= start_d;
            busy_q    <= busy_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
            timer_q   <= timer_d;
            hold_q    <= hold_d;
        end
    end

    assign seqStart     = start_q;
    assign seqSelect    = sel_q;
    assign busy         = busy_q;
    assign pending      = pending_q;
    assign overrunFlags = overrun_q;
    assign timeoutFlag  = timeout_q;

endmodule

// File: tb/tb_sequence_start_arbiter.sv
// Directed bench: expected seqStart events (select, cycle) are queued by the
// stimulus and matched by an independent monitor; state checks are inline.
module tb_sequence_start_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [3:0]  mask;
    logic [15:0] hold;
    logic        align;
    logic        done;
    logic        clr;
    logic        seq_start;
    logic [1:0]  seq_select;
    logic        busy;
    logic [3:0]  pending;
    logic [3:0]  overrun;
    logic        timeout;

    typedef struct {
        int sel;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    sequence_start_arbiter #(
        .BUSY_TIMEOUT (20),
        .TIMEOUT_WIDTH(5)
    ) dut (
        .evgTxClk    (clk),
        .evgTxReset_n(rst_n),
        .req         (req),
        .enableMask  (mask),
        .holdoffTicks(hold),
        .alignStrobe (align),
        .seqDone     (done),
        .clearFlags  (clr),
        .seqStart    (seq_start),
        .seqSelect   (seq_select),
        .busy        (busy),
        .pending     (pending),
        .overrunFlags(overrun),
        .timeoutFlag (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every seqStart must match the head of the scoreboard.
    always @(negedge clk) begin
        if (seq_start) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL start_unexpected: got sel=%0d at cycle %0d, required none", seq_select, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (e.sel != int'(seq_select) || e.cyc != cyc) begin
                    bad++;
                    $display("FAIL start_match: got sel=%0d cycle=%0d, required sel=%0d cycle=%0d",
                             seq_select, cyc, e.sel, e.cyc);
                end else begin
                    $display("start sel=%0d cycle=%0d ok", seq_select, cyc);
                end
            end
        end else if (sb.size() != 0 && sb[0].cyc < cyc) begin
            exp_t e;
            e = sb.pop_front();
            total++;
            bad++;
            $display("FAIL start_missing: got no start, required sel=%0d at cycle %0d", e.sel, e.cyc);
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end else begin
            $display("check %s = %0h ok", name, act);
        end
    endtask

    task automatic expect_start(input int sel, input int at);
        exp_t e;
        e.sel = sel;
        e.cyc = at;
        sb.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int b;
        rst_n = 1'b0;
        req   = 4'd0;
        mask  = 4'hF;
        hold  = 16'd0;
        align = 1'b0;
        done  = 1'b0;
        clr   = 1'b0;
        tick(3);
        check("rst_busy", 32'(busy), 0);
        check("rst_pending", 32'(pending), 0);
        check("rst_start", 32'(seq_start), 0);
        check("rst_flags", {27'd0, timeout, overrun}, 0);
        rst_n = 1'b1;
        tick(2);

        // Two simultaneous requests, holdoff 10, alignment always present.
        hold  = 16'd10;
        align = 1'b1;
        b     = cyc;
        req   = 4'b0110;
        expect_start(1, b + 3);
        expect_start(2, b + 20);
        tick();
        req = 4'd0;
        check("pend_both", 32'(pending), 32'h6);
        tick(5);
        done = 1'b1;
        tick();
        done = 1'b0;
        check("pend_after_grant", 32'(pending), 32'h4);
        check("busy_holdoff", 32'(busy), 1);
        tick(16);
        hold = 16'd0;
        done = 1'b1;
        tick();
        done  = 1'b0;
        align = 1'b0;
        tick(2);

        // Grant waits for the next alignment strobe, and only that one.
        b   = cyc;
        req = 4'b0001;
        expect_start(0, b + 11);
        tick();
        req = 4'd0;
        tick(9);
        align = 1'b1;
        tick();
        align = 1'b0;
        tick(3);
        done = 1'b1;
        tick();
        done = 1'b0;
        tick(5);
        align = 1'b1;
        tick();
        align = 1'b0;
        tick(3);

        // Repeated request while pending -> overrun, single start; masked request ignored.
        b   = cyc;
        req = 4'b1000;
        expect_start(3, b + 5);
        tick(3);
        req = 4'd0;
        check("overrun_set", 32'(overrun), 32'h8);
        check("pend_3", 32'(pending), 32'h8);
        tick();
        align = 1'b1;
        tick();
        align = 1'b0;
        tick(2);
        done = 1'b1;
        tick();
        done = 1'b0;
        tick(2);
        mask = 4'b0111;
        req  = 4'b1000;
        tick();
        req = 4'd0;
        check("masked_pend", 32'(pending), 0);
        check("overrun_hold", 32'(overrun), 32'h8);
        clr = 1'b1;
        tick();
        clr  = 1'b0;
        mask = 4'hF;
        check("overrun_clear", 32'(overrun), 0);
        tick(2);

        // Request coinciding with its own START-cycle clear: set wins, no overrun.
        b     = cyc;
        align = 1'b1;
        req   = 4'b0100;
        expect_start(2, b + 3);
        expect_start(2, b + 8);
        tick();
        req = 4'd0;
        tick(2);
        req = 4'b0100;
        tick();
        req = 4'd0;
        check("coincide_pend", 32'(pending), 32'h4);
        check("coincide_overrun", 32'(overrun), 0);
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        tick(4);
        done = 1'b1;
        tick();
        done = 1'b0;
        tick(2);

        // Withheld seqDone forces release after the busy timeout.
        b   = cyc;
        req = 4'b0010;
        expect_start(1, b + 3);
        tick();
        req = 4'd0;
        tick(22);
        check("pre_timeout_busy", 32'(busy), 1);
        check("pre_timeout_flag", 32'(timeout), 0);
        tick();
        check("timeout_flag", 32'(timeout), 1);
        check("timeout_idle", 32'(busy), 0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("timeout_clear", 32'(timeout), 0);
        tick(2);

        // Asynchronous reset during BUSY abandons the grant and the queued request.
        b   = cyc;
        req = 4'b0100;
        expect_start(2, b + 3);
        tick();
        req = 4'd0;
        tick(4);
        req = 4'b0001;
        tick();
        req = 4'd0;
        check("pre_rst_busy", 32'(busy), 1);
        check("pre_rst_pend", 32'(pending), 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_outputs", {22'd0, seq_start, seq_select, busy, pending, overrun, timeout}, 0);
        tick();
        rst_n = 1'b1;
        tick(2);
        done = 1'b1;
        tick();
        done = 1'b0;
        tick(10);
        check("late_done_busy", 32'(busy), 0);
        check("late_done_pend", 32'(pending), 0);
        align = 1'b0;
        tick(3);
        check("scoreboard_empty", 32'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sequence_start_arbiter.md
SEQUENCE_START_ARBITER -- requirements
Module: sequence_start_arbiter

Interface
REQ-001 SHALL have parameter BUSY_TIMEOUT, default 1000000, meaning evgTxClk cycles allowed between seqStart and seqDone before forced release.
REQ-002 SHALL have parameter TIMEOUT_WIDTH, default 21, meaning busy-timeout counter width (must hold BUSY_TIMEOUT).
REQ-003 SHALL have port evgTxClk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port evgTxReset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req  input  4  single-cycle start-request pulses, index 0 highest priority.
REQ-006 SHALL have port enableMask  input  4  per-requester enable; 0 ignores that requester.
REQ-007 SHALL have port holdoffTicks  input  16  minimum idle cycles after each sequence completes.
REQ-008 SHALL have port alignStrobe  input  1  one-cycle booster/accumulator alignment marker.
REQ-009 SHALL have port seqDone  input  1  one-cycle pulse from sequencer: sequence finished.
REQ-010 SHALL have port clearFlags  input  1  one-cycle pulse clearing sticky flags.
REQ-011 SHALL have port seqStart  output  1  one-cycle sequencer start pulse.
REQ-012 SHALL have port seqSelect  output  2  index of granted requester, stable from START until next grant.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-014 SHALL have port pending  output  4  latched, not-yet-served requests.
REQ-015 SHALL have port overrunFlags  output  4  sticky: request arrived while already pending.
REQ-016 SHALL have port timeoutFlag  output  1  sticky: BUSY_TIMEOUT expired.

Function
REQ-017 SHALL implement states IDLE, AWAIT_ALIGN, START, BUSY, HOLDOFF.
REQ-018 SHALL set pending[i] the cycle after req[i]=1 with enableMask[i]=1; pending[i] SHALL be cleared while enableMask[i]=0.
REQ-019 IDLE: if any pending bit set, SHALL latch lowest set index into seqSelect and go to AWAIT_ALIGN next cycle.
REQ-020 AWAIT_ALIGN: on alignStrobe=1 SHALL go to START; the granted request SHALL proceed even if its enable drops here.
REQ-021 START: seqStart=1 for exactly that cycle, pending[seqSelect] cleared, next state BUSY.
REQ-022 BUSY: on seqDone SHALL load holdoff counter with holdoffTicks and go to HOLDOFF; seqDone outside BUSY SHALL be ignored.
REQ-023 BUSY: after BUSY_TIMEOUT cycles without seqDone SHALL set timeoutFlag and go to HOLDOFF as if seqDone.
REQ-024 HOLDOFF: SHALL decrement each cycle and enter IDLE the cycle after count reaches 0; holdoffTicks=0 SHALL pass straight to IDLE.
REQ-025 Latency: req pulse in cycle N with IDLE and alignStrobe already high at N+2 SHALL yield seqStart at N+3.
REQ-026 If req[seqSelect] coincides with the START-cycle clear, set SHALL win (pending stays 1) and no overrun SHALL be flagged.
REQ-027 overrunFlags[i] SHALL set when req[i]=1, enableMask[i]=1 and pending[i]=1 is not being cleared that cycle.
REQ-028 clearFlags SHALL clear overrunFlags and timeoutFlag; a simultaneous set condition SHALL win.
REQ-029 Priority SHALL be evaluated only in IDLE; requests arriving later wait for the next IDLE.

Reset
REQ-030 evgTxReset_n=0 SHALL immediately force IDLE, seqStart=0, seqSelect=0, busy=0, pending=0, overrunFlags=0, timeoutFlag=0, counters=0.
REQ-031 Reset asserted mid-sequence SHALL abandon the grant; no seqStart SHALL follow release until a new req.

Verification
REQ-032 req=4'b0110 same cycle, mask=4'hF, holdoffTicks=10 -> seqSelect=1 started first; seqSelect=2 seqStart no earlier than 11 cycles after seqDone.
REQ-033 req[0] pulse, alignStrobe every 100 cycles -> seqStart exactly one cycle after the next alignStrobe, never otherwise.
REQ-034 Grant issued, seqDone withheld -> timeoutFlag=1 at BUSY_TIMEOUT, arbiter returns to IDLE; clearFlags -> timeoutFlag=0.
REQ-035 req[3] twice while pending[3]=1 -> overrunFlags=4'b1000, one seqStart only; req[3] during mask[3]=0 -> ignored.
REQ-036 evgTxReset_n low during BUSY -> all outputs 0 asynchronously; late seqDone after release -> no effect.
